// File: rtl/ball_pkg.sv
// Shared types for the ball movement controller: FSM states, map cell codes
// and bit positions of the one-hot movement vector {right,left,down,up}.
package ball_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WAIT_ACK,
    ST_COMMIT,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    FLOOR = 2'd0,
    WALL  = 2'd1,
    HOLE  = 2'd2,
    GOAL  = 2'd3
  } cell_t;

  localparam int MV_UP    = 0;
  localparam int MV_DOWN  = 1;
  localparam int MV_LEFT  = 2;
  localparam int MV_RIGHT = 3;

endpackage

// File: rtl/tilt_dir_sel.sv
// Combinational tilt decoder: 9-bit magnitudes, deadzone test and one-hot
// direction pick (larger axis wins, ties go to x).
module tilt_dir_sel
  import ball_pkg::*;
#(
  parameter logic [7:0] DEADZONE = 8'd16
) (
  input  logic [7:0] tilt_x,
  input  logic [7:0] tilt_y,
  output logic       move_valid,
  output logic [3:0] dir
);

  logic [8:0] mag_x;
  logic [8:0] mag_y;
  logic       x_sel;

  // Nine bits so that -128 becomes +128 instead of wrapping.
  always_comb begin
    mag_x = tilt_x[7] ? (9'd0 - {1'b1, tilt_x}) : {1'b0, tilt_x};
    mag_y = tilt_y[7] ? (9'd0 - {1'b1, tilt_y}) : {1'b0, tilt_y};
    x_sel = (mag_x >= mag_y);
    move_valid = x_sel ? (mag_x > {1'b0, DEADZONE}) : (mag_y > {1'b0, DEADZONE});
    dir = 4'b0000;
    if (x_sel) begin
      if (tilt_x[7]) dir[MV_LEFT] = 1'b1;
      else           dir[MV_RIGHT] = 1'b1;
    end else begin
      if (tilt_y[7]) dir[MV_UP] = 1'b1;
      else           dir[MV_DOWN] = 1'b1;
    end
  end

endmodule

// File: rtl/ball_move_ctrl.sv
// Ball move controller: turns tilt into at most one checked move per step_tick.
// Optional GOAL_DETECT_EN adds the win output and halts on a goal cell.
module ball_move_ctrl
  import ball_pkg::*;
#(
  parameter int         COORD_W     = 6,
  parameter logic [7:0] DEADZONE    = 8'd16,
  parameter int         ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step_tick,
  input  logic [7:0]           tilt_x,
  input  logic [7:0]           tilt_y,
  input  logic [COORD_W-1:0]   ball_x,
  input  logic [COORD_W-1:0]   ball_y,
  output logic                 map_rd_req,
  output logic [2*COORD_W-1:0] map_rd_addr,
  input  logic                 map_rd_ack,
  input  logic [1:0]           map_value,
  output logic [3:0]           movement,
  output logic                 blocked,
  output logic                 fell,
  output logic                 busy
`ifdef GOAL_DETECT_EN
  ,
  output logic                 win
`endif
);

  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  state_t             state;
  logic [3:0]         dir_reg;
  logic [CNT_W-1:0]   timeout_cnt;
  logic               hole_reg;
  logic               move_valid;
  logic [3:0]         dir_sel;
  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic               wrap;
`ifdef GOAL_DETECT_EN
  logic               goal_reg;
`endif

  tilt_dir_sel #(
    .DEADZONE(DEADZONE)
  ) u_tilt_dir_sel (
    .tilt_x    (tilt_x),
    .tilt_y    (tilt_y),
    .move_valid(move_valid),
    .dir       (dir_sel)
  );

  // Neighbour cell and edge detection; an edge move is refused, never wrapped.
  always_comb begin
    cand_x = ball_x;
    cand_y = ball_y;
    wrap   = 1'b0;
    if (dir_sel[MV_RIGHT]) begin
      cand_x = ball_x + COORD_W'(1);
      wrap   = (ball_x == COORD_MAX);
    end else if (dir_sel[MV_LEFT]) begin
      cand_x = ball_x - COORD_W'(1);
      wrap   = (ball_x == '0);
    end else if (dir_sel[MV_DOWN]) begin
      cand_y = ball_y + COORD_W'(1);
      wrap   = (ball_y == COORD_MAX);
    end else if (dir_sel[MV_UP]) begin
      cand_y = ball_y - COORD_W'(1);
      wrap   = (ball_y == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      movement    <= '0;
      map_rd_req  <= 1'b0;
      map_rd_addr <= '0;
      blocked     <= 1'b0;
      fell        <= 1'b0;
      busy        <= 1'b0;
      timeout_cnt <= '0;
      dir_reg     <= '0;
      hole_reg    <= 1'b0;
`ifdef GOAL_DETECT_EN
      goal_reg    <= 1'b0;
      win         <= 1'b0;
`endif
    end else begin
      map_rd_req <= 1'b0;
      blocked    <= 1'b0;
      movement   <= '0;
      case (state)
        ST_IDLE: begin
          if (step_tick && move_valid) begin
            dir_reg <= dir_sel;
            if (wrap) begin
              blocked <= 1'b1;
            end else begin
              map_rd_req  <= 1'b1;
              map_rd_addr <= {cand_y, cand_x};
              timeout_cnt <= '0;
              busy        <= 1'b1;
              state       <= ST_LOOKUP;
            end
          end
        end
        // An ack is honoured in the request cycle as well as while waiting.
        ST_LOOKUP, ST_WAIT_ACK: begin
          if (map_rd_ack) begin
            case (cell_t'(map_value))
              WALL: begin
                blocked <= 1'b1;
                busy    <= 1'b0;
                state   <= ST_IDLE;
              end
              HOLE: begin
                hole_reg <= 1'b1;
                movement <= dir_reg;
                state    <= ST_COMMIT;
              end
`ifdef GOAL_DETECT_EN
              GOAL: begin
                goal_reg <= 1'b1;
                movement <= dir_reg;
                state    <= ST_COMMIT;
              end
`endif
              default: begin
                movement <= dir_reg;
                state    <= ST_COMMIT;
              end
            endcase
          end else if (state == ST_LOOKUP) begin
            state <= ST_WAIT_ACK;
          end else if (timeout_cnt == CNT_LAST) begin
            blocked <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            timeout_cnt <= timeout_cnt + CNT_W'(1);
          end
        end
        ST_COMMIT: begin
          if (hole_reg) begin
            fell  <= 1'b1;
            state <= ST_HALT;
          end
`ifdef GOAL_DETECT_EN
          else if (goal_reg) begin
            win   <= 1'b1;
            state <= ST_HALT;
          end
`endif
          else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_move_ctrl.sv
// Randomised and directed bench for ball_move_ctrl against a per-transaction
// model derived from the tilt/map rules; honours GOAL_DETECT_EN.
module tb_ball_move_ctrl;

  localparam int CW  = 6;
  localparam int TO  = 15;
  localparam int DZ  = 16;
  localparam int WIN = 22;

  logic              clk = 1'b0;
  logic              reset;
  logic              step_tick;
  logic [7:0]        tilt_x;
  logic [7:0]        tilt_y;
  logic [CW-1:0]     ball_x;
  logic [CW-1:0]     ball_y;
  logic              map_rd_req;
  logic [2*CW-1:0]   map_rd_addr;
  logic              map_rd_ack;
  logic [1:0]        map_value;
  logic [3:0]        movement;
  logic              blocked;
  logic              fell;
  logic              busy;
`ifdef GOAL_DETECT_EN
  logic              win;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ball_move_ctrl #(
    .COORD_W    (CW),
    .DEADZONE   (8'd16),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .step_tick  (step_tick),
    .tilt_x     (tilt_x),
    .tilt_y     (tilt_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .map_rd_req (map_rd_req),
    .map_rd_addr(map_rd_addr),
    .map_rd_ack (map_rd_ack),
    .map_value  (map_value),
    .movement   (movement),
    .blocked    (blocked),
    .fell       (fell),
    .busy       (busy)
`ifdef GOAL_DETECT_EN
    ,
    .win        (win)
`endif
  );

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    step_tick = 1'b0;
    map_rd_ack = 1'b0;
    map_value = 2'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One step request: the model predicts, per cycle after the tick, what every
  // output must show. d = ack delay after the request (-1: never acked).
  task automatic run_step(input string name, input int tx, input int ty,
                          input int bx, input int by, input int d, input int val,
                          input bit poke, output bit halted);
    int ax, ay, dx, dy, nx, ny, oc;
    bit act, wrap, req, acked, is_wall, is_goal, halts;
    bit exp_req, exp_blk, exp_busy, exp_fell, exp_win;
    logic [3:0] mv, exp_mov;
    logic [2*CW-1:0] exp_addr;
    ax = (tx < 0) ? -tx : tx;
    ay = (ty < 0) ? -ty : ty;
    act = (ax > DZ) || (ay > DZ);
    dx = 0;
    dy = 0;
    if (ax >= ay) dx = (tx > 0) ? 1 : -1;
    else          dy = (ty > 0) ? 1 : -1;
    nx = bx + dx;
    ny = by + dy;
    wrap = (nx < 0) || (nx >= (1 << CW)) || (ny < 0) || (ny >= (1 << CW));
    mv = (dx > 0) ? 4'b1000 : (dx < 0) ? 4'b0100 : (dy > 0) ? 4'b0010 : 4'b0001;
    req = act && !wrap;
    acked = req && (d >= 0) && (d <= TO);
    oc = acked ? (2 + d) : (2 + TO);
    is_wall = !acked || (val == 1);
    is_goal = 1'b0;
`ifdef GOAL_DETECT_EN
    is_goal = acked && (val == 3);
`endif
    halts = (acked && (val == 2)) || is_goal;
    exp_addr = {ny[CW-1:0], nx[CW-1:0]};
    tilt_x = tx[7:0];
    tilt_y = ty[7:0];
    ball_x = bx[CW-1:0];
    ball_y = by[CW-1:0];
    for (int c = 0; c < WIN; c++) begin
      @(negedge clk);
      exp_req  = req && (c == 1);
      exp_blk  = act && (wrap ? (c == 1) : (req && is_wall && (c == oc)));
      exp_mov  = (req && !is_wall && (c == oc)) ? mv : 4'b0000;
      exp_busy = req && (c >= 1) && ((c < oc) || (!is_wall && (c == oc)) || (halts && (c > oc)));
      exp_fell = acked && (val == 2) && (c > oc);
      exp_win  = is_goal && (c > oc);
      checks++;
      if (map_rd_req !== exp_req) begin
        errors++;
        $display("FAIL %s c%0d map_rd_req got %b exp %b", name, c, map_rd_req, exp_req);
      end
      checks++;
      if (blocked !== exp_blk) begin
        errors++;
        $display("FAIL %s c%0d blocked got %b exp %b", name, c, blocked, exp_blk);
      end
      checks++;
      if (movement !== exp_mov) begin
        errors++;
        $display("FAIL %s c%0d movement got %b exp %b", name, c, movement, exp_mov);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL %s c%0d busy got %b exp %b", name, c, busy, exp_busy);
      end
      checks++;
      if (fell !== exp_fell) begin
        errors++;
        $display("FAIL %s c%0d fell got %b exp %b", name, c, fell, exp_fell);
      end
`ifdef GOAL_DETECT_EN
      checks++;
      if (win !== exp_win) begin
        errors++;
        $display("FAIL %s c%0d win got %b exp %b", name, c, win, exp_win);
      end
`endif
      if (req && (c >= 1) && (c <= oc)) begin
        checks++;
        if (map_rd_addr !== exp_addr) begin
          errors++;
          $display("FAIL %s c%0d map_rd_addr got %h exp %h", name, c, map_rd_addr, exp_addr);
        end
      end
      step_tick  = (c == 0) || (poke && exp_busy && (c == 2));
      map_rd_ack = acked && (c == 1 + d);
      map_value  = (c == 1 + d) ? 2'(val) : 2'($urandom_range(0, 3));
    end
    step_tick = 1'b0;
    map_rd_ack = 1'b0;
    halted = halts;
    $display("step %s tilt=(%0d,%0d) ball=(%0d,%0d) ack_delay=%0d val=%0d halted=%0b",
             name, tx, ty, bx, by, d, val, halts);
  endtask

  task automatic check_halted(input string name, input bit ef, input bit ew);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (map_rd_req !== 1'b0 || movement !== 4'b0000) begin
        errors++;
        $display("FAIL %s c%0d req/mov got %b/%b exp 0/0000", name, c, map_rd_req, movement);
      end
      checks++;
      if (busy !== 1'b1 || fell !== ef) begin
        errors++;
        $display("FAIL %s c%0d busy/fell got %b/%b exp 1/%b", name, c, busy, fell, ef);
      end
`ifdef GOAL_DETECT_EN
      checks++;
      if (win !== ew) begin
        errors++;
        $display("FAIL %s c%0d win got %b exp %b", name, c, win, ew);
      end
`else
      if (ew) $display("note: win not built");
`endif
      step_tick = 1'b1;
      tilt_x = 8'd40;
      tilt_y = 8'd0;
      map_rd_ack = 1'b1;
      map_value = 2'd0;
    end
    step_tick = 1'b0;
    map_rd_ack = 1'b0;
    $display("halt %s ticks ignored", name);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2;
    checks++;
    if ({map_rd_req, map_rd_addr, movement, blocked, fell, busy} !== '0) begin
      errors++;
      $display("FAIL reset_async outputs got %b exp 0",
               {map_rd_req, map_rd_addr, movement, blocked, fell, busy});
    end
    do_reset;
    @(negedge clk);
    checks++;
    if ({map_rd_req, map_rd_addr, movement, blocked, fell, busy} !== '0) begin
      errors++;
      $display("FAIL reset_release outputs got %b exp 0",
               {map_rd_req, map_rd_addr, movement, blocked, fell, busy});
    end
`ifdef GOAL_DETECT_EN
    checks++;
    if (win !== 1'b0) begin
      errors++;
      $display("FAIL reset_win got %b exp 0", win);
    end
`endif
    $display("reset outputs cleared");
  endtask

  task automatic test_basic_move;
    bit h;
    do_reset;
    run_step("move_right", 40, 10, 5, 5, 1, 0, 0, h);
    run_step("move_down", 10, 40, 20, 30, 1, 0, 0, h);
    run_step("move_up_lookup_ack", 3, -90, 10, 20, 0, 0, 0, h);
    run_step("move_left_m128", -128, 127, 30, 7, 3, 0, 0, h);
  endtask

  task automatic test_tie_wall;
    bit h;
    do_reset;
    run_step("tie_wall", -20, -20, 5, 5, 1, 1, 0, h);
    run_step("tie_pos_floor", 60, 60, 9, 9, 2, 0, 0, h);
  endtask

  task automatic test_wrap_deadzone;
    bit h;
    do_reset;
    run_step("wrap_up", 0, -50, 7, 0, 1, 0, 0, h);
    run_step("wrap_right", 100, 3, 63, 9, 1, 0, 0, h);
    run_step("dz_5", 5, 0, 5, 5, 1, 0, 0, h);
    run_step("dz_16", 16, -16, 5, 5, 1, 0, 0, h);
    run_step("dz_17", -17, 0, 5, 5, 2, 0, 0, h);
  endtask

  task automatic test_timeout;
    bit h;
    do_reset;
    run_step("timeout", 40, 10, 5, 5, -1, 0, 1, h);
    run_step("ack_last", 40, 10, 5, 5, TO, 0, 1, h);
  endtask

  task automatic test_hole;
    bit h;
    do_reset;
    run_step("hole", 40, 10, 5, 5, 1, 2, 1, h);
    check_halted("hole_halt", 1'b1, 1'b0);
    do_reset;
  endtask

  task automatic test_goal;
    bit h;
    do_reset;
    run_step("goal", 40, 10, 5, 5, 1, 3, 0, h);
`ifdef GOAL_DETECT_EN
    check_halted("goal_halt", 1'b0, 1'b1);
    do_reset;
`else
    run_step("after_goal", -40, 0, 6, 5, 1, 0, 0, h);
`endif
  endtask

  task automatic test_reset_midwait;
    do_reset;
    @(negedge clk);
    tilt_x = 8'd40;
    tilt_y = 8'd10;
    ball_x = 6'd5;
    ball_y = 6'd5;
    step_tick = 1'b1;
    @(negedge clk);
    step_tick = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || map_rd_addr !== {6'd5, 6'd6}) begin
      errors++;
      $display("FAIL midwait_pre busy/addr got %b/%h exp 1/%h", busy, map_rd_addr, {6'd5, 6'd6});
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({map_rd_req, map_rd_addr, movement, blocked, fell, busy} !== '0) begin
      errors++;
      $display("FAIL midwait_reset outputs got %b exp 0",
               {map_rd_req, map_rd_addr, movement, blocked, fell, busy});
    end
    @(negedge clk);
    reset = 1'b1;
    map_rd_ack = 1'b1;
    map_value = 2'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (movement !== 4'b0000 || busy !== 1'b0 || map_rd_req !== 1'b0) begin
        errors++;
        $display("FAIL midwait_abandon c%0d mov/busy/req got %b/%b/%b exp 0000/0/0",
                 c, movement, busy, map_rd_req);
      end
    end
    map_rd_ack = 1'b0;
    $display("reset mid-wait abandoned read");
  endtask

  task automatic test_random;
    bit h;
    int tx, ty, bx, by, d, r, val;
    do_reset;
    for (int i = 0; i < 40; i++) begin
      tx = $urandom_range(0, 255) - 128;
      ty = $urandom_range(0, 255) - 128;
      bx = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 63 : 0) : $urandom_range(0, 63);
      by = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 63 : 0) : $urandom_range(0, 63);
      r = $urandom_range(0, 19);
      d = (r <= TO) ? r : -1;
      val = $urandom_range(0, 3);
      run_step("rand", tx, ty, bx, by, d, val, $urandom_range(0, 1) == 1, h);
      if (h) do_reset;
    end
  endtask

  initial begin
    reset = 1'b0;
    step_tick = 1'b0;
    tilt_x = 8'd0;
    tilt_y = 8'd0;
    ball_x = '0;
    ball_y = '0;
    map_rd_ack = 1'b0;
    map_value = 2'd0;
    test_reset;
    test_basic_move;
    test_tie_wall;
    test_wrap_deadzone;
    test_timeout;
    test_hole;
    test_goal;
    test_reset_midwait;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
